// File: rtl/cdi_bus_pkg.sv
// cdi_bus_pkg: shared FSM state type, bus widths and region-compare helper for the CD-i bus decoder
package cdi_bus_pkg;
  localparam int BUS_ADDR_W = 24;
  localparam int BUS_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} bus_state_t;
  function automatic logic region_hit(input logic [BUS_ADDR_W-1:0] addr, input logic [BUS_ADDR_W-1:0] base,
                                      input logic [BUS_ADDR_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction
endpackage

// File: rtl/cdi_bus_watchdog.sv
// cdi_bus_watchdog: counts consecutive cycles with run high and flags the cycle the count hits TIMEOUT_CYCLES
//   clk, resetn (async active-low) | run: WAIT-state indicator | expired: last allowed WAIT cycle reached
module cdi_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic expired
);
  logic [9:0] cnt_q, cnt_d;
  always_comb cnt_d = run ? cnt_q + 10'd1 : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // cnt_q holds the number of WAIT cycles already completed, so this fires in WAIT cycle TIMEOUT_CYCLES
  assign expired = run && (cnt_q == 10'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cdi_bus_decoder.sv
// cdi_bus_decoder: SCC68070 bus decoder with one-hot chip selects, wait-state/slave ack and bus error
//   in : clk, resetn (async active-low), addr[23:1], as, uds, lds, write_strobe, slave_dout, slave_ack
//   out: data_in, bus_ack, bus_err, slave_cs (one-hot), slave_write (write_strobe forwarded to slaves)
//   CDI_BUS_TIMEOUT_EN: when defined, a watchdog turns a WAIT lasting TIMEOUT_CYCLES into bus_err
module cdi_bus_decoder
  import cdi_bus_pkg::*;
#(
  parameter int                                      NUM_REGIONS    = 5,
  parameter logic [NUM_REGIONS-1:0][BUS_ADDR_W-1:0] REGION_BASE    = '0,
  parameter logic [NUM_REGIONS-1:0][BUS_ADDR_W-1:0] REGION_MASK    = '0,
  parameter logic [NUM_REGIONS-1:0][3:0]            REGION_WAIT    = {NUM_REGIONS{4'd1}},
  parameter logic [NUM_REGIONS-1:0]                 REGION_EXT_ACK = '0,
  parameter int                                      TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [23:1]                       addr,
  input  logic                              as,
  input  logic                              uds,
  input  logic                              lds,
  input  logic                              write_strobe,
  output logic [BUS_DATA_W-1:0]             data_in,
  output logic                              bus_ack,
  output logic                              bus_err,
  output logic [NUM_REGIONS-1:0]            slave_cs,
  output logic                              slave_write,
  input  logic [NUM_REGIONS*BUS_DATA_W-1:0] slave_dout,
  input  logic [NUM_REGIONS-1:0]            slave_ack
);
  localparam int SW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  bus_state_t            state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d, hit_idx;
  logic [3:0]            wait_q, wait_d;
  logic [BUS_DATA_W-1:0] data_q, data_d;
  logic                  hit_any, start, done, expired;
  // scan downwards so the lowest matching index is the one left standing
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (region_hit({addr, 1'b0}, REGION_BASE[i], REGION_MASK[i])) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign start = (state_q == IDLE) && as && (uds || lds);
  assign done  = REGION_EXT_ACK[sel_q] ? slave_ack[sel_q] : (wait_q == 4'd0);
`ifdef CDI_BUS_TIMEOUT_EN
  cdi_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .run    (state_q == WAIT),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  // an abort outranks completion, and completion outranks the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = hit_any ? WAIT : ERR;
      WAIT:    state_d = !as ? IDLE : done ? ACK : expired ? ERR : WAIT;
      default: if (!uds && !lds) state_d = IDLE;
    endcase
  end
  always_comb begin
    sel_d  = start ? hit_idx : sel_q;
    wait_d = start ? REGION_WAIT[hit_idx] : (state_q == WAIT && wait_q != 4'd0) ? wait_q - 4'd1 : wait_q;
    data_d = (state_q == WAIT && state_d == ACK) ? slave_dout[BUS_DATA_W*sel_q +: BUS_DATA_W] : data_q;
  end
  always_comb begin
    slave_cs    = (state_q == WAIT || state_q == ACK) ? NUM_REGIONS'(NUM_REGIONS'(1) << sel_q) : '0;
    bus_ack     = state_q == ACK;
    bus_err     = state_q == ERR;
    slave_write = write_strobe;
  end
  assign data_in = data_q;
endmodule

// File: tb/tb_cdi_bus_decoder.sv
// tb_cdi_bus_decoder: randomized self-checking bench for cdi_bus_decoder against a cycle-count reference model
`timescale 1ns/1ps
module tb_cdi_bus_decoder;
  localparam int N = 5;
  localparam int T = 16;
  // regions: 0 ROM, 1 CDIC (ext ack), 2 NVRAM (W=0), 3 MCD212 (W=5), 4 overlaps ROM below 0x100000 (W=2)
  localparam logic [N-1:0][23:0] BASE  = {24'h000000, 24'h400000, 24'h320000, 24'h300000, 24'h000000};
  localparam logic [N-1:0][23:0] MASK  = {24'hF00000, 24'hF00000, 24'hFF0000, 24'hFF0000, 24'hF80000};
  localparam logic [N-1:0][3:0]  WAITS = {4'd2, 4'd5, 4'd0, 4'd0, 4'd1};
  localparam logic [N-1:0]       EXT   = 5'b00010;

  logic          clk, resetn, cpu_as, uds, lds, we;
  logic [23:1]   addr;
  logic [15:0]   data_in;
  logic          bus_ack, bus_err, slave_write;
  logic [N-1:0]  slave_cs, slave_ack;
  logic [N*16-1:0] slave_dout;
  int            vectors = 0, errs = 0;
  logic [15:0]   last_data = '0;

  cdi_bus_decoder #(
    .NUM_REGIONS(N), .REGION_BASE(BASE), .REGION_MASK(MASK), .REGION_WAIT(WAITS),
    .REGION_EXT_ACK(EXT), .TIMEOUT_CYCLES(T)
  ) u_dut (
    .clk(clk), .resetn(resetn), .addr(addr), .as(cpu_as), .uds(uds), .lds(lds),
    .write_strobe(we), .data_in(data_in), .bus_ack(bus_ack), .bus_err(bus_err),
    .slave_cs(slave_cs), .slave_write(slave_write), .slave_dout(slave_dout), .slave_ack(slave_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  function automatic int exp_region(input logic [23:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
    return -1;
  endfunction

  // k: first cycle slave_ack is high (0 = never); pre_ack: slave_ack high on the start cycle only;
  // abort: cycle at which as drops (0 = none)
  task automatic access(input string name, input logic [23:0] a, input int k, input bit pre_ack, input int abort);
    int r, e, c, ab;
    bit is_ack;
    logic [N-1:0] ecs;
    logic [N+1:0] exp_o;
    logic [15:0] exp_d;
    r = exp_region(a);
    is_ack = 1'b0;
    e = 1;
    ab = abort;
    ecs = '0;
    exp_d = '0;
    if (r >= 0) begin
      ecs = N'(N'(1) << r);
      if (EXT[r]) begin
        e = 1 << 30;
        if (k > 0) begin e = k + 1; is_ack = 1'b1; end
`ifdef CDI_BUS_TIMEOUT_EN
        if (T + 1 < e) begin e = T + 1; is_ack = 1'b0; end
`endif
      end else begin
        e = 2 + int'(WAITS[r]);
        is_ack = 1'b1;
      end
    end
    if (ab == 0 && e > 1000) ab = 1000;
    addr = a[23:1];
    cpu_as = 1'b1;
    uds = 1'b1;
    lds = 1'($urandom);
    we = 1'($urandom);
    slave_ack = pre_ack ? ecs : '0;
    for (int i = 0; i < N; i++) slave_dout[16*i +: 16] = 16'($urandom);
    if (r >= 0) exp_d = slave_dout[16*r +: 16];
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      exp_o = (c < e) ? {ecs, 2'b00} : {is_ack ? ecs : N'(0), is_ack, !is_ack};
      vectors++;
      if ({slave_cs, bus_ack, bus_err} !== exp_o || slave_write !== we) begin
        errs++;
        $display("FAIL %s cycle %0d: got cs=%b ack=%b err=%b wr=%b, expected cs/ack/err=%b wr=%b",
                 name, c, slave_cs, bus_ack, bus_err, slave_write, exp_o, we);
      end
      if (c == e && is_ack) last_data = exp_d;
      vectors++;
      if (data_in !== last_data) begin
        errs++;
        $display("FAIL %s data cycle %0d: got %h, expected %h", name, c, data_in, last_data);
      end
      if (c == e || c == ab) break;
      slave_ack = (k > 0 && c >= k) ? ecs : '0;
      for (int i = 0; i < N; i++) slave_dout[16*i +: 16] = 16'($urandom);
      if (r >= 0) exp_d = slave_dout[16*r +: 16];
    end
    cpu_as = 1'b0;
    uds = 1'b0;
    lds = 1'b0;
    slave_ack = '0;
    @(negedge clk);
    vectors++;
    if ({slave_cs, bus_ack, bus_err} !== '0 || data_in !== last_data) begin
      errs++;
      $display("FAIL %s idle: got cs=%b ack=%b err=%b data=%h, expected 0/0/0 data=%h",
               name, slave_cs, bus_ack, bus_err, data_in, last_data);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cpu_as = 1'b0; uds = 1'b0; lds = 1'b0; we = 1'b0;
    addr = '0; slave_ack = '0; slave_dout = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({slave_cs, bus_ack, bus_err} !== '0 || data_in !== 16'h0) begin
      errs++;
      $display("FAIL reset: got cs=%b ack=%b err=%b data=%h, expected all 0", slave_cs, bus_ack, bus_err, data_in);
    end
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({slave_cs, bus_ack, bus_err} !== '0) begin
      errs++;
      $display("FAIL reset_release: got cs=%b ack=%b err=%b, expected 0", slave_cs, bus_ack, bus_err);
    end
  endtask

  task automatic test_reset_mid;
    addr = 23'h200008;
    cpu_as = 1'b1; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    vectors++;
    if (slave_cs !== 5'b01000) begin
      errs++;
      $display("FAIL reset_mid cs: got %b, expected 01000", slave_cs);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++;
    if ({slave_cs, bus_ack, bus_err} !== '0 || data_in !== 16'h0) begin
      errs++;
      $display("FAIL reset_mid: got cs=%b ack=%b err=%b data=%h, expected all 0", slave_cs, bus_ack, bus_err, data_in);
    end
    last_data = '0;
    cpu_as = 1'b0; uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    access("after_reset", 24'h000100, 0, 1'b0, 0);
    access("after_reset_ext", 24'h303000, 16, 1'b0, 0);
  endtask

  task automatic test_basic;
    access("rom_read", 24'h000100, 0, 1'b0, 0);
    access("cdic_ext", 24'h303C02, 5, 1'b0, 0);
    access("pre_ack", 24'h300010, 3, 1'b1, 0);
    access("unmapped", 24'h700000, 0, 1'b0, 0);
    access("nvram_w0", 24'h320000, 0, 1'b0, 0);
    access("mcd_w5", 24'h4FFFFE, 0, 1'b0, 0);
  endtask

  task automatic test_overlap;
    access("overlap_r0", 24'h000200, 0, 1'b0, 0);
    access("overlap_r4", 24'h0A0000, 0, 1'b0, 0);
  endtask

  task automatic test_timeout;
    access("timeout", 24'h300000, 0, 1'b0, 0);
    access("tie_ack", 24'h300000, 16, 1'b0, 0);
    access("late_ack", 24'h300000, 17, 1'b0, 0);
    access("abort", 24'h300000, 0, 1'b0, 5);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) access("b2b", (i % 2 == 0) ? 24'h320040 : 24'h000040, 0, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [23:0] a;
    int sel;
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, N));
      a = 24'($urandom);
      if (sel < N) a = (BASE[sel] & MASK[sel]) | (a & ~MASK[sel]);
      a[0] = 1'b0;
      access("random", a, int'($urandom_range(1, 20)), 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overlap;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
